rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
- Shares one read port of the negedge-registered instruction/data ROM between two requesters: port 0 is fetch, port 1 is the data/loader path.
- Arbitrates round-robin, drives the ROM address from a register, and captures the ROM word.
- Returns the word to the granted requester over a valid/ready response handshake.
- Sits between the processor's memory-side requesters and the ROM instance.

Parameters:
- DATA_WIDTH, 32, width of a ROM word and of the response data.
- ADDRESS_WIDTH, 12, width of the ROM and request addresses.

Ports:
- clk  in  1  system clock; the ROM samples rom_addr on its falling edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 read request.
- req0_addr  in  ADDRESS_WIDTH  port 0 word address.
- req0_ready  out  1  port 0 request accepted this cycle.
- resp0_valid  out  1  port 0 response data valid.
- resp0_data  out  DATA_WIDTH  port 0 read data.
- resp0_ready  in  1  port 0 consumes the response.
- req1_valid, req1_addr, req1_ready, resp1_valid, resp1_data, resp1_ready: same as port 0, for port 1.
- rom_addr  out  ADDRESS_WIDTH  registered address to the ROM addr input.
- rom_data  in  DATA_WIDTH  ROM dataOut.

Behaviour:
- Clock is clk; reset is asynchronous and active-high. Reset forces:
  - state IDLE; rom_addr 0; resp data register 0;
  - owner 0; last_grant 1, so port 0 wins the first tie;
  - all ready and valid outputs 0.
- Reset mid-operation aborts any read in flight. The pending response is dropped and never presented.
- States:
  - IDLE: no transaction.
  - READ: address issued; the ROM samples it at the next falling edge.
  - RESP: data held for the owner.
- can_accept = (state==IDLE) or (state==RESP and the owner's resp_ready=1). Combinational.
- Grant, combinational:
  - Only one valid: that port.
  - Both valid: the port != last_grant.
- reqN_ready = can_accept and grant==N and reqN_valid. At most one ready is high in any cycle.
- Accept edge (valid&ready at posedge A):
  - rom_addr <= addr; owner <= N; last_grant <= N; state <= READ.
- Posedge A+1, in READ:
  - resp data register <= rom_data. The ROM updated it at the falling edge between A and A+1.
  - state <= RESP.
- respN_valid = (state==RESP and owner==N).
  - Data is held stable until respN_ready.
  - The response for an accepted request appears exactly 2 posedges after acceptance.
- Response handshake at the RESP posedge:
  - If a new request is accepted at the same edge: state <= READ with the new address. Back-to-back throughput is 1 word per 2 cycles.
  - Otherwise: state <= IDLE.
- Backpressure: while RESP waits on resp_ready=0, both req_ready are 0 and rom_addr is held.
- Requesters must hold valid and addr stable until ready. Dropping valid before ready is legal and withdraws the request.
- The non-owner's resp_ready is ignored.
- rom_addr changes only on accept edges or reset, never mid-READ.
- Address wrap: no arithmetic is performed. Addresses pass through unmodified; 0 and 2^ADDRESS_WIDTH-1 are both legal.

Test Plan:
- Reset, ROM word[5]=0xDEADBEEF, req0 addr 5 in IDLE -> req0_ready=1 that cycle; resp0_valid=1 with 0xDEADBEEF 2 edges later; resp1_valid stays 0.
- Both ports valid in the same cycle after reset (port0 addr 1, port1 addr 2) -> port0 granted first; with resp_ready tied 1, port1 is accepted at the edge port0's response completes; resp1_data=word[2].
- Both ports held valid continuously with resp_ready=1 -> grants alternate 0,1,0,1; one response every 2 cycles; no port is starved.
- resp0_ready held 0 for 5 cycles while req1 valid -> resp0_data stable, req1_ready=0, rom_addr unchanged; when resp0_ready is raised, req1 is accepted the same cycle.
- Assert reset during READ (1 cycle after accept) -> outputs return to reset values immediately (async); no response for the aborted read; next req0 addr 4095 returns word[4095].
- Withdraw req1_valid while RESP stalls, then re-raise it with addr 0 -> no phantom transaction; addr 0 is read correctly.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// -----------------------------------------------------------------------------
// rom_read_arbiter
//
// Shares the single read port of a negedge-registered ROM between two
// requesters (port 0 = instruction fetch, port 1 = data/loader path).
//
// Each read takes the following steps:
//   1. Accept edge: the ROM address is registered onto rom_addr.
//   2. Falling edge: the ROM samples rom_addr and updates rom_data.
//   3. Next rising edge: rom_data is captured into the response register.
//   4. The word is then presented to the owning port over a valid/ready
//      handshake.
//
// Arbitration is round-robin on ties. The port that was not granted last
// time wins.
//
// Ports:
//   clk          system clock (ROM samples rom_addr on the falling edge)
//   reset        asynchronous, active-high reset
//   reqN_valid   port N read request
//   reqN_addr    port N word address
//   reqN_ready   port N request accepted this cycle
//   respN_valid  port N response data valid
//   respN_data   port N read data
//   respN_ready  port N consumes the response
//   rom_addr     registered address driven to the ROM
//   rom_data     ROM data output
// -----------------------------------------------------------------------------

// Protocol checker: invariants of the arbiter, evaluated in simulation only.
module rom_read_arbiter_checker #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input logic                     clk,
    input logic                     reset,
    input logic                     in_read,
    input logic                     req0_ready,
    input logic                     req1_ready,
    input logic                     resp0_valid,
    input logic                     resp0_ready,
    input logic [DATA_WIDTH-1:0]    resp0_data,
    input logic                     resp1_valid,
    input logic                     resp1_ready,
    input logic [DATA_WIDTH-1:0]    resp1_data,
    input logic [ADDRESS_WIDTH-1:0] rom_addr
);

    // Only one requester may be accepted per cycle.
    a_one_ready: assert property (@(posedge clk) disable iff (reset)
        !(req0_ready && req1_ready))
        else $error("two ready outputs high together");

    // Only one port may own the response register.
    a_one_resp: assert property (@(posedge clk) disable iff (reset)
        !(resp0_valid && resp1_valid))
        else $error("two response valids high together");

    // The ROM address must not move while the ROM is being read.
    a_addr_hold: assert property (@(posedge clk) disable iff (reset)
        in_read |=> $stable(rom_addr))
        else $error("rom_addr changed during READ");

    // A stalled response keeps its valid and its data.
    a_resp0_hold: assert property (@(posedge clk) disable iff (reset)
        (resp0_valid && !resp0_ready) |=> (resp0_valid && $stable(resp0_data)))
        else $error("port 0 response dropped or changed under stall");

    a_resp1_hold: assert property (@(posedge clk) disable iff (reset)
        (resp1_valid && !resp1_ready) |=> (resp1_valid && $stable(resp1_data)))
        else $error("port 1 response dropped or changed under stall");

endmodule

module rom_read_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0_valid,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    output logic                     req0_ready,
    output logic                     resp0_valid,
    output logic [DATA_WIDTH-1:0]    resp0_data,
    input  logic                     resp0_ready,

    input  logic                     req1_valid,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    output logic                     req1_ready,
    output logic                     resp1_valid,
    output logic [DATA_WIDTH-1:0]    resp1_data,
    input  logic                     resp1_ready,

    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [ADDRESS_WIDTH-1:0] rom_addr_r;
    logic [DATA_WIDTH-1:0]    data_r;
    logic                     owner_r;
    logic                     last_grant_r;

    logic                     grant_s;
    logic                     owner_ready_s;
    logic                     can_accept_s;
    logic                     ready0_s;
    logic                     ready1_s;
    logic                     accept_s;
    logic [ADDRESS_WIDTH-1:0] accept_addr_s;

    // Round-robin grant: a lone requester wins; on a tie the port not granted last time wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && !req1_valid) begin
            grant_s = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            grant_s = 1'b1;
        end else if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Acceptance window: idle, or the current response is retiring this cycle.
    always_comb begin
        owner_ready_s = owner_r ? resp1_ready : resp0_ready;
        can_accept_s  = 1'b0;
        case (state_r)
            ST_IDLE: can_accept_s = 1'b1;
            ST_RESP: can_accept_s = owner_ready_s;
            ST_READ: can_accept_s = 1'b0;
            default: can_accept_s = 1'b0;
        endcase
        // Ready outputs are forced low while reset is held.
        if (reset) begin
            can_accept_s = 1'b0;
        end else begin
            can_accept_s = can_accept_s;
        end
    end

    // Per-port ready and the address of the request being accepted.
    always_comb begin
        ready0_s      = can_accept_s && !grant_s && req0_valid;
        ready1_s      = can_accept_s &&  grant_s && req1_valid;
        accept_s      = ready0_s || ready1_s;
        accept_addr_s = grant_s ? req1_addr : req0_addr;
    end

    // Next-state logic for the IDLE / READ / RESP transaction sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_next_s = ST_RESP;
            end
            ST_RESP: begin
                // A new accept at the retiring edge chains straight into READ.
                if (owner_ready_s && accept_s) begin
                    state_next_s = ST_READ;
                end else if (owner_ready_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, address, ownership and data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            rom_addr_r   <= {ADDRESS_WIDTH{1'b0}};
            data_r       <= {DATA_WIDTH{1'b0}};
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            // The address only moves on accept edges, so it is stable across READ.
            if (accept_s) begin
                rom_addr_r   <= accept_addr_s;
                owner_r      <= grant_s;
                last_grant_r <= grant_s;
            end
            // The ROM updated rom_data on the falling edge inside READ.
            if (state_r == ST_READ) begin
                data_r <= rom_data;
            end
        end
    end

    assign req0_ready  = ready0_s;
    assign req1_ready  = ready1_s;
    assign resp0_valid = (state_r == ST_RESP) && !owner_r;
    assign resp1_valid = (state_r == ST_RESP) &&  owner_r;
    assign resp0_data  = data_r;
    assign resp1_data  = data_r;
    assign rom_addr    = rom_addr_r;

    rom_read_arbiter_checker #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_checker (
        .clk         (clk),
        .reset       (reset),
        .in_read     (state_r == ST_READ),
        .req0_ready  (ready0_s),
        .req1_ready  (ready1_s),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp0_data  (resp0_data),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp1_data  (resp1_data),
        .rom_addr    (rom_addr_r)
    );

endmodule

// File: tb/tb_rom_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_read_arbiter
//
// Self-checking bench for rom_read_arbiter.
// - Models a negedge-registered ROM.
// - Drives table-driven vectors, followed by hand-written corner sequences.
// - A per-port scoreboard queue holds the expected word and the accept cycle
//   of every accepted request. Entries are compared, and popped, as the
//   responses are produced.
// -----------------------------------------------------------------------------
module tb_rom_read_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          req0_ready, req1_ready;
    logic          resp0_valid, resp1_valid;
    logic [DW-1:0] resp0_data, resp1_data;
    logic          resp0_ready, resp1_ready;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            acc_cyc;
    } sb_t;

    sb_t  sbq[2][$];
    logic prev_valid[2];

    typedef struct {
        logic          do_reset;
        logic          v0;
        logic [AW-1:0] a0;
        logic          v1;
        logic [AW-1:0] a1;
        logic          rr0;
        logic          rr1;
        logic          e_rdy0;
        logic          e_rdy1;
        logic          e_rv0;
        logic          e_rv1;
    } vec_t;

    vec_t vecs[$];

    rom_read_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_ready  (req0_ready),
        .resp0_valid (resp0_valid),
        .resp0_data  (resp0_data),
        .resp0_ready (resp0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_ready  (req1_ready),
        .resp1_valid (resp1_valid),
        .resp1_data  (resp1_data),
        .resp1_ready (resp1_ready),
        .rom_addr    (rom_addr),
        .rom_data    (rom_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        if (a == 12'd5) return 32'hDEAD_BEEF;
        return {4'hA, a, 4'h5, a};
    endfunction

    // Negedge-registered ROM model.
    always @(negedge clk) rom_q <= rom_word(rom_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drv(input logic v0, input logic [AW-1:0] a0, input logic v1,
                       input logic [AW-1:0] a1, input logic rr0, input logic rr1);
        req0_valid  = v0;
        req0_addr   = a0;
        req1_valid  = v1;
        req1_addr   = a1;
        resp0_ready = rr0;
        resp1_ready = rr1;
    endtask

    task automatic check_port(input int p, input logic valid, input logic ready,
                              input logic [DW-1:0] data);
        if (valid) begin
            if (sbq[p].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL phantom_resp%0d: got valid data %0h expected no response", p, data);
            end else begin
                if (!prev_valid[p]) chk($sformatf("latency%0d", p), 64'(cyc - sbq[p][0].acc_cyc), 64'd2);
                chk($sformatf("resp%0d_data", p), data, sbq[p][0].data);
                if (ready) void'(sbq[p].pop_front());
            end
        end
        prev_valid[p] = valid;
    endtask

    // Settle after the negedge drive, then record accepts and check responses.
    task automatic sample();
        #1;
        chk("one_ready", 64'(req0_ready & req1_ready), 64'd0);
        if (req0_valid && req0_ready) sbq[0].push_back('{rom_word(req0_addr), cyc});
        if (req1_valid && req1_ready) sbq[1].push_back('{rom_word(req1_addr), cyc});
        check_port(0, resp0_valid, resp0_ready, resp0_data);
        check_port(1, resp1_valid, resp1_ready, resp1_data);
    endtask

    task automatic advance();
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_sb();
        sbq[0].delete();
        sbq[1].delete();
        prev_valid[0] = 1'b0;
        prev_valid[1] = 1'b0;
    endtask

    task automatic apply_reset();
        drv(1'b0, 12'd0, 1'b0, 12'd0, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_resp_data", 64'(resp0_data), 64'd0);
        chk("rst_valids", 64'({resp0_valid, resp1_valid}), 64'd0);
        chk("rst_readys", 64'({req0_ready, req1_ready}), 64'd0);
        clear_sb();
        @(negedge clk);
        reset = 1'b0;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drv(1'b0, 12'd0, 1'b0, 12'd0, 1'b1, 1'b1);
        clear_sb();

        // rst, v0, a0, v1, a1, rr0, rr1, e_rdy0, e_rdy1, e_rv0, e_rv1
        // single request on port 0 (word 5 = DEADBEEF)
        vecs.push_back('{1'b1, 1'b1, 12'd5,  1'b0, 12'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 12'd0,  1'b0, 12'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 12'd0,  1'b0, 12'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 12'd0,  1'b0, 12'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        // simultaneous requests after reset: port 0 first, port 1 on retire edge
        vecs.push_back('{1'b1, 1'b1, 12'd1,  1'b1, 12'd2,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 12'd0,  1'b1, 12'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 12'd0,  1'b1, 12'd2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 12'd0,  1'b0, 12'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 12'd0,  1'b0, 12'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 12'd0,  1'b0, 12'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0});
        // both ports held valid: grants alternate 0,1,0,1,0
        vecs.push_back('{1'b1, 1'b1, 12'd10, 1'b1, 12'd20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 12'd10, 1'b1, 12'd20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 12'd10, 1'b1, 12'd20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 12'd10, 1'b1, 12'd20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 12'd10, 1'b1, 12'd20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 12'd10, 1'b1, 12'd20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 12'd10, 1'b1, 12'd20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 12'd10, 1'b1, 12'd20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 12'd10, 1'b1, 12'd20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 12'd0,  1'b0, 12'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 12'd0,  1'b0, 12'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 12'd0,  1'b0, 12'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        @(negedge clk);
        cyc++;

        foreach (vecs[i]) begin
            if (vecs[i].do_reset) apply_reset();
            drv(vecs[i].v0, vecs[i].a0, vecs[i].v1, vecs[i].a1, vecs[i].rr0, vecs[i].rr1);
            sample();
            chk($sformatf("v%0d_req0_ready", i), 64'(req0_ready), 64'(vecs[i].e_rdy0));
            chk($sformatf("v%0d_req1_ready", i), 64'(req1_ready), 64'(vecs[i].e_rdy1));
            chk($sformatf("v%0d_resp0_valid", i), 64'(resp0_valid), 64'(vecs[i].e_rv0));
            chk($sformatf("v%0d_resp1_valid", i), 64'(resp1_valid), 64'(vecs[i].e_rv1));
            advance();
        end
        chk("table_sb0_empty", 64'(sbq[0].size()), 64'd0);
        chk("table_sb1_empty", 64'(sbq[1].size()), 64'd0);

        // Backpressure: port 0 stalls its response for 5 cycles while port 1 waits.
        apply_reset();
        drv(1'b1, 12'd7, 1'b0, 12'd0, 1'b1, 1'b1);
        sample();
        chk("bp_acc0", 64'(req0_ready), 64'd1);
        advance();
        drv(1'b0, 12'd0, 1'b1, 12'd8, 1'b0, 1'b1);
        sample();
        advance();
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("bp_req1_ready", 64'(req1_ready), 64'd0);
            chk("bp_resp0_valid", 64'(resp0_valid), 64'd1);
            chk("bp_rom_addr", 64'(rom_addr), 64'd7);
            advance();
        end
        resp0_ready = 1'b1;
        sample();
        chk("bp_release_req1_ready", 64'(req1_ready), 64'd1);
        advance();
        drv(1'b0, 12'd0, 1'b0, 12'd0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            sample();
            advance();
        end
        chk("bp_sb1_empty", 64'(sbq[1].size()), 64'd0);

        // Reset during READ aborts the read; then read the top address.
        apply_reset();
        drv(1'b1, 12'd100, 1'b0, 12'd0, 1'b1, 1'b1);
        sample();
        chk("ab_acc0", 64'(req0_ready), 64'd1);
        advance();
        drv(1'b0, 12'd0, 1'b0, 12'd0, 1'b1, 1'b1);
        sample();
        reset = 1'b1;
        #1;
        chk("ab_rom_addr", 64'(rom_addr), 64'd0);
        chk("ab_resp0_valid", 64'(resp0_valid), 64'd0);
        chk("ab_resp_data", 64'(resp0_data), 64'd0);
        clear_sb();
        @(negedge clk);
        reset = 1'b0;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("ab_no_resp", 64'({resp0_valid, resp1_valid}), 64'd0);
            advance();
        end
        drv(1'b1, 12'd4095, 1'b0, 12'd0, 1'b1, 1'b1);
        sample();
        chk("ab_acc_top", 64'(req0_ready), 64'd1);
        advance();
        drv(1'b0, 12'd0, 1'b0, 12'd0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            sample();
            advance();
        end
        chk("ab_sb0_empty", 64'(sbq[0].size()), 64'd0);

        // Withdraw port 1 during a stall, then re-raise it with address 0.
        apply_reset();
        drv(1'b1, 12'd9, 1'b0, 12'd0, 1'b0, 1'b1);
        sample();
        advance();
        drv(1'b0, 12'd0, 1'b1, 12'd3, 1'b0, 1'b1);
        sample();
        advance();
        sample();
        chk("wd_stall_req1_ready", 64'(req1_ready), 64'd0);
        advance();
        drv(1'b0, 12'd0, 1'b0, 12'd3, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            sample();
            advance();
        end
        drv(1'b0, 12'd0, 1'b1, 12'd0, 1'b0, 1'b1);
        sample();
        chk("wd_reraise_stalled", 64'(req1_ready), 64'd0);
        advance();
        resp0_ready = 1'b1;
        sample();
        chk("wd_accept_addr0", 64'(req1_ready), 64'd1);
        advance();
        drv(1'b0, 12'd0, 1'b0, 12'd0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            sample();
            advance();
        end
        chk("wd_sb0_empty", 64'(sbq[0].size()), 64'd0);
        chk("wd_sb1_empty", 64'(sbq[1].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
